// File: rtl/ram_2port_bist.sv
// rtl/ram_2port_bist.sv - parametrised simple dual-port RAM with built-in self-test sequencer
//
// Purpose:
//   Generic inferred simple dual-port RAM (one write port, one read port,
//   single clock) plus a start-triggered BIST FSM. One run writes a
//   selectable pattern to every address, reads every address back, compares
//   each word and reports pass/fail, the mismatch count and the first failing
//   address.
//
// Parameters:
//   DATA_W  RAM word width (even, >= 2)
//   ADDR_W  address width, DEPTH = 2**ADDR_W
//   RD_LAT  read latency: 1 = registered read address, 2 = plus output register
//
// Ports:
//   clk             clock for RAM and FSM
//   rst_n           asynchronous active-low reset
//   start           level, sampled in IDLE/DONE; launches one run
//   mode[1:0]       pattern select, latched on accepted start
//   err_inj         (only with RAM_2PORT_BIST_ERR_INJ_EN) flips bit 0 of word 0
//   busy            high while a run is in progress
//   done            one-cycle pulse on DONE entry
//   pass            1 = last run had zero mismatches (valid when not busy)
//   err_cnt         mismatch count of last/current run
//   first_err_addr  address of first mismatch, 0 if none
//
// Optional feature macro: RAM_2PORT_BIST_ERR_INJ_EN

module ram_2port_bist #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
`ifdef RAM_2PORT_BIST_ERR_INJ_EN
    input  logic              err_inj,
`endif
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [ADDR_W-1:0]   addr;
    logic [1:0]          flush_cnt;
    logic [1:0]          mode_q;
    logic                accept;
    logic                wren;
    logic                rden;
    logic                addr_last;
    logic                flush_last;
    logic                flush_end;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   exp_now;
    logic [ADDR_W-1:0]   rdaddress;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [DATA_W-1:0]   q;

    logic [RD_LAT-1:0]   vld_d;
    logic [DATA_W-1:0]   exp_d  [RD_LAT];
    logic [ADDR_W-1:0]   addr_d [RD_LAT];
    logic                mismatch;

    // Expected word for address a under pattern m.
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                  input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] base;
        logic [DATA_W-1:0] cb;
        base = DATA_W'(a);
        cb   = {(DATA_W/2){2'b01}};
        if (a[0]) begin
            cb = ~cb;
        end
        case (m)
            2'd0:    pattern = base;
            2'd1:    pattern = ~base;
            2'd2:    pattern = cb;
            default: pattern = a[0] ? '0 : '1;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign addr_last  = (addr == {ADDR_W{1'b1}});
    assign flush_last = (flush_cnt == 2'(RD_LAT - 1));
    assign flush_end  = (state == S_FLUSH) && flush_last;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        wren      = 1'b0;
        rden      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                wren = 1'b1;
                if (addr_last) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                rden = 1'b1;
                if (addr_last) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_last) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_WRITE) || (state == S_READ) || (state == S_FLUSH);

    // One shared address counter: it wraps from DEPTH-1 to 0 at the end of
    // the write sweep, which is exactly where the read sweep must begin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr      <= '0;
            flush_cnt <= '0;
            mode_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr   <= '0;
                mode_q <= mode;
            end else if (wren || rden) begin
                addr <= addr + 1'b1;
            end
            if (state == S_FLUSH) begin
                flush_cnt <= flush_cnt + 1'b1;
            end else begin
                flush_cnt <= '0;
            end
        end
    end

    assign exp_now   = pattern(mode_q, addr);
    assign rdaddress = addr;

`ifdef RAM_2PORT_BIST_ERR_INJ_EN
    logic inj_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_q <= 1'b0;
        end else if (accept) begin
            inj_q <= err_inj;
        end
    end

    // Deliberately corrupt word 0 so the compare path can be proven live.
    assign wdata = exp_now ^ DATA_W'(inj_q && (addr == '0));
`else
    assign wdata = exp_now;
`endif

    // ------------------------------------------------------------------
    // Memory (contents are not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wren) begin
            mem[addr] <= wdata;
        end
        rd_addr_q <= rdaddress;
    end

    generate
        if (RD_LAT == 2) begin : g_out_reg
            logic [DATA_W-1:0] q_r;
            always_ff @(posedge clk) begin
                q_r <= mem[rd_addr_q];
            end
            assign q = q_r;
        end else begin : g_no_out_reg
            assign q = mem[rd_addr_q];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Compare pipeline: expected word, address and valid travel RD_LAT
    // stages so they line up with q.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_d <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                exp_d[i]  <= '0;
                addr_d[i] <= '0;
            end
        end else begin
            vld_d[0]  <= rden;
            exp_d[0]  <= exp_now;
            addr_d[0] <= addr;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_d[i]  <= vld_d[i-1];
                exp_d[i]  <= exp_d[i-1];
                addr_d[i] <= addr_d[i-1];
            end
        end
    end

    assign mismatch = vld_d[RD_LAT-1] && (q != exp_d[RD_LAT-1]);

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
        end else begin
            if (accept) begin
                err_cnt        <= '0;
                first_err_addr <= '0;
            end else if (mismatch) begin
                err_cnt <= err_cnt + 1'b1;
                if (err_cnt == '0) begin
                    first_err_addr <= addr_d[RD_LAT-1];
                end
            end
            done <= flush_end;
            // The final word is compared in the last flush cycle, so its
            // mismatch must be folded in here rather than read from err_cnt.
            if (flush_end) begin
                pass <= (err_cnt == '0) && !mismatch;
            end
        end
    end

endmodule

// File: tb/tb_ram_2port_bist.sv
// tb/tb_ram_2port_bist.sv - self-checking bench for ram_2port_bist

module tb_ram_2port_bist;

    logic clk;
    logic rst_n;

    logic       start0, start1, start2;
    logic [1:0] mode0, mode1, mode2;
    logic       inj0, inj1, inj2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic       pass0, pass1, pass2;
    logic [8:0] ec0, ec1;
    logic [4:0] ec2;
    logic [7:0] fa0, fa1;
    logic [3:0] fa2;

    int n_cmp;
    int n_bad;

    ram_2port_bist #(.DATA_W(8), .ADDR_W(8), .RD_LAT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode0),
`ifdef RAM_2PORT_BIST_ERR_INJ_EN
        .err_inj(inj0),
`endif
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(ec0), .first_err_addr(fa0)
    );

    ram_2port_bist #(.DATA_W(8), .ADDR_W(8), .RD_LAT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1),
`ifdef RAM_2PORT_BIST_ERR_INJ_EN
        .err_inj(inj1),
`endif
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(ec1), .first_err_addr(fa1)
    );

    ram_2port_bist #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2),
`ifdef RAM_2PORT_BIST_ERR_INJ_EN
        .err_inj(inj2),
`endif
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(ec2), .first_err_addr(fa2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word from the pattern rules, using plain integer arithmetic.
    function automatic int model_pat(int dw, int m, int a);
        int mask;
        int v;
        mask = (1 << dw) - 1;
        v    = a & mask;
        case (m)
            0:       return v;
            1:       return mask - v;
            2:       return (a % 2 == 0) ? (mask / 3) : (mask - mask / 3);
            default: return (a % 2 == 0) ? mask : 0;
        endcase
    endfunction

    // Launch one run on u0 and observe it. Optionally corrupts nb words in
    // RAM after the write sweep and pulses start again at busy cycle pulse_at.
    task automatic run_u0(input logic [1:0] m, input int pulse_at, input int nb,
                          input logic inj, output int blen, output int dcnt,
                          output logic p, output int ec, output int fa,
                          output int bad_a);
        int bad_b;
        logic drop;
        blen  = 0;
        dcnt  = 0;
        drop  = 1'b0;
        bad_a = $urandom_range(16, 100);
        bad_b = $urandom_range(150, 250);
        mode0 = m;
        inj0  = inj;
        @(negedge clk);
        start0 = 1'b1;
        for (int c = 0; c < 2 * 256 + 1 + 8; c++) begin
            @(negedge clk);
            if (c == 0 || drop) begin
                start0 = 1'b0;
                drop   = 1'b0;
            end
            if (busy0) blen++;
            if (done0) dcnt++;
            if (busy0 && blen == pulse_at) begin
                start0 = 1'b1;
                drop   = 1'b1;
            end
            if (busy0 && blen == 257) begin
                if (nb >= 1) u0.mem[bad_a] = u0.mem[bad_a] ^ 8'h80;
                if (nb >= 2) u0.mem[bad_b] = u0.mem[bad_b] ^ 8'h01;
            end
        end
        p  = pass0;
        ec = int'(ec0);
        fa = int'(fa0);
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        mode0  = 2'd0; mode1  = 2'd0; mode2  = 2'd0;
        inj0   = 1'b0; inj1   = 1'b0; inj2   = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy0, done0, pass0, ec0, fa0} !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%0d done=%0d pass=%0d err_cnt=%0d first=%0d required all 0",
                     busy0, done0, pass0, ec0, fa0);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_patterns;
        int off;
        int blen, dcnt, ec, fa, ba, a, m;
        logic p;
        off = $urandom_range(0, 3);
        for (int k = 0; k < 4; k++) begin
            m = (k + off) % 4;
            run_u0(2'(m), -1, 0, 1'b0, blen, dcnt, p, ec, fa, ba);
            n_cmp++;
            if (blen !== 513 || dcnt !== 1) begin
                n_bad++;
                $display("FAIL pat_timing mode %0d: busy=%0d done_pulses=%0d required 513/1", m, blen, dcnt);
            end
            n_cmp++;
            if (p !== 1'b1 || ec !== 0 || fa !== 0) begin
                n_bad++;
                $display("FAIL pat_result mode %0d: pass=%0d err=%0d first=%0d required 1/0/0", m, p, ec, fa);
            end
            for (int j = 0; j < 6; j++) begin
                a = (j == 0) ? 0 : (j == 1) ? 255 : $urandom_range(0, 255);
                n_cmp++;
                if (int'(u0.mem[a]) !== model_pat(8, m, a)) begin
                    n_bad++;
                    $display("FAIL pat_ram mode %0d addr %0d: got %0h required %0h",
                             m, a, u0.mem[a], model_pat(8, m, a));
                end
            end
        end
    endtask

    task automatic test_mismatch;
        int blen, dcnt, ec, fa, ba;
        logic p;
        for (int nb = 1; nb <= 2; nb++) begin
            run_u0(2'($urandom_range(0, 3)), -1, nb, 1'b0, blen, dcnt, p, ec, fa, ba);
            n_cmp++;
            if (p !== 1'b0 || ec !== nb || fa !== ba) begin
                n_bad++;
                $display("FAIL mismatch_%0d: pass=%0d err=%0d first=%0d required 0/%0d/%0d",
                         nb, p, ec, fa, nb, ba);
            end
            n_cmp++;
            if (blen !== 513 || dcnt !== 1) begin
                n_bad++;
                $display("FAIL mismatch_timing_%0d: busy=%0d done_pulses=%0d required 513/1", nb, blen, dcnt);
            end
        end
    endtask

    task automatic test_ignored_start;
        int blen, dcnt, ec, fa, ba;
        logic p;
        run_u0(2'd0, 100, 0, 1'b0, blen, dcnt, p, ec, fa, ba);
        n_cmp++;
        if (blen !== 513 || dcnt !== 1 || p !== 1'b1) begin
            n_bad++;
            $display("FAIL ignored_start: busy=%0d done_pulses=%0d pass=%0d required 513/1/1", blen, dcnt, p);
        end
        n_cmp++;
        if (busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL ignored_start_idle: busy=%0d required 0", busy0);
        end
    endtask

    task automatic test_reset_mid_run;
        int blen, dcnt, ec, fa, ba;
        logic p;
        blen  = 0;
        mode0 = 2'd1;
        @(negedge clk);
        start0 = 1'b1;
        for (int c = 0; c < 400 && blen < 256 + 51; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (busy0) blen++;
            if (blen == 257) u0.mem[10] = u0.mem[10] ^ 8'h04;
        end
        n_cmp++;
        if (blen !== 256 + 51 || ec0 !== 9'd1) begin
            n_bad++;
            $display("FAIL pre_reset: busy_cycles=%0d err=%0d required %0d/1", blen, ec0, 256 + 51);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy0 !== 1'b0 || ec0 !== 9'd0 || pass0 !== 1'b0 || fa0 !== 8'd0) begin
            n_bad++;
            $display("FAIL async_reset: busy=%0d err=%0d pass=%0d first=%0d required 0/0/0/0",
                     busy0, ec0, pass0, fa0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_u0(2'd2, -1, 0, 1'b0, blen, dcnt, p, ec, fa, ba);
        n_cmp++;
        if (blen !== 513 || dcnt !== 1 || p !== 1'b1 || ec !== 0) begin
            n_bad++;
            $display("FAIL after_reset: busy=%0d done=%0d pass=%0d err=%0d required 513/1/1/0",
                     blen, dcnt, p, ec);
        end
    endtask

    task automatic test_rd_lat2;
        int blen, dcnt;
        blen  = 0;
        dcnt  = 0;
        mode1 = 2'd2;
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 0; c < 2 * 256 + 2 + 8; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (busy1) blen++;
            if (done1) dcnt++;
        end
        n_cmp++;
        if (blen !== 514 || dcnt !== 1 || pass1 !== 1'b1 || ec1 !== 9'd0) begin
            n_bad++;
            $display("FAIL rd_lat2: busy=%0d done=%0d pass=%0d err=%0d required 514/1/1/0",
                     blen, dcnt, pass1, ec1);
        end
        n_cmp++;
        if (int'(u1.mem[4]) !== model_pat(8, 2, 4) || int'(u1.mem[5]) !== model_pat(8, 2, 5)) begin
            n_bad++;
            $display("FAIL rd_lat2_ram: mem4=%0h mem5=%0h required %0h/%0h",
                     u1.mem[4], u1.mem[5], model_pat(8, 2, 4), model_pat(8, 2, 5));
        end
    endtask

    task automatic test_back_to_back;
        int seg, gap, runs, dcnt;
        logic prev;
        seg   = 0;
        gap   = 0;
        runs  = 0;
        dcnt  = 0;
        prev  = 1'b0;
        mode2 = 2'd3;
        @(negedge clk);
        start2 = 1'b1;
        for (int c = 0; c < 3 * 34 + 6; c++) begin
            @(negedge clk);
            if (c == 68) start2 = 1'b0;
            if (busy2) begin
                if (!prev && runs > 0) begin
                    n_cmp++;
                    if (gap !== 1) begin
                        n_bad++;
                        $display("FAIL b2b_gap run %0d: gap=%0d required 1", runs, gap);
                    end
                end
                seg++;
            end else begin
                if (prev) begin
                    runs++;
                    gap = 0;
                    n_cmp++;
                    if (seg !== 33 || done2 !== 1'b1 || pass2 !== 1'b1) begin
                        n_bad++;
                        $display("FAIL b2b_run %0d: busy=%0d done=%0d pass=%0d required 33/1/1",
                                 runs, seg, done2, pass2);
                    end
                    seg = 0;
                end
                gap++;
            end
            if (done2) dcnt++;
            prev = busy2;
        end
        n_cmp++;
        if (runs !== 3 || dcnt !== 3) begin
            n_bad++;
            $display("FAIL b2b_count: runs=%0d done_pulses=%0d required 3/3", runs, dcnt);
        end
        n_cmp++;
        if (int'(u2.mem[2]) !== model_pat(16, 3, 2) || int'(u2.mem[3]) !== model_pat(16, 3, 3)) begin
            n_bad++;
            $display("FAIL b2b_ram: mem2=%0h mem3=%0h required %0h/%0h",
                     u2.mem[2], u2.mem[3], model_pat(16, 3, 2), model_pat(16, 3, 3));
        end
    endtask

`ifdef RAM_2PORT_BIST_ERR_INJ_EN
    task automatic test_err_inj;
        int blen, dcnt, ec, fa, ba;
        logic p;
        run_u0(2'd1, -1, 0, 1'b1, blen, dcnt, p, ec, fa, ba);
        n_cmp++;
        if (p !== 1'b0 || ec !== 1 || fa !== 0) begin
            n_bad++;
            $display("FAIL err_inj: pass=%0d err=%0d first=%0d required 0/1/0", p, ec, fa);
        end
        n_cmp++;
        if (int'(u0.mem[0]) !== (model_pat(8, 1, 0) ^ 1)) begin
            n_bad++;
            $display("FAIL err_inj_ram: mem0=%0h required %0h", u0.mem[0], model_pat(8, 1, 0) ^ 1);
        end
        run_u0(2'd1, -1, 0, 1'b0, blen, dcnt, p, ec, fa, ba);
        n_cmp++;
        if (p !== 1'b1 || ec !== 0) begin
            n_bad++;
            $display("FAIL err_inj_rerun: pass=%0d err=%0d required 1/0", p, ec);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_patterns();
        test_ignored_start();
        test_mismatch();
        test_reset_mid_run();
        test_rd_lat2();
        test_back_to_back();
`ifdef RAM_2PORT_BIST_ERR_INJ_EN
        test_err_inj();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
